// File: rtl/fp32_multiplier_pipe.sv
// Fully pipelined binary32 multiplier: fixed 7-cycle latency, one operation per cycle.
// No backpressure: every input strobe yields exactly one result pulse, in order.
module fp32_multiplier_pipe #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] inp_a,
  input  logic [DATA_WIDTH-1:0] inp_b,
  input  logic                  inp_data_ready,
  output logic                  out_product_ready,
  output logic [DATA_WIDTH-1:0] out_product
);

  localparam logic [31:0] QNAN = 32'h7FC00000;

  // Stage valids S1..S6; S7 valid is out_product_ready itself.
  logic [6:1] vld;

  logic [31:0]       s1_a, s1_b;

  logic              s2_sign, s2_special;
  logic [31:0]       s2_special_val;
  logic signed [9:0] s2_exp;
  logic [23:0]       s2_ma, s2_mb;

  logic              s3_sign, s3_special;
  logic [31:0]       s3_special_val;
  logic signed [9:0] s3_exp;
  logic [35:0]       s3_pp_lo, s3_pp_hi;

  logic              s4_sign, s4_special;
  logic [31:0]       s4_special_val;
  logic signed [9:0] s4_exp;
  logic [47:0]       s4_prod;

  logic              s5_sign, s5_special;
  logic [31:0]       s5_special_val;
  logic signed [9:0] s5_exp;
  logic [23:0]       s5_sig;
  logic              s5_guard, s5_sticky;

  logic              s6_sign, s6_special;
  logic [31:0]       s6_special_val;
  logic signed [9:0] s6_exp;
  logic [22:0]       s6_frac;

  // S2 classification of the captured operands
  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sign_c;
  logic        special_c;
  logic [31:0] special_val_c;

  always_comb begin
    ea     = s1_a[30:23];
    eb     = s1_b[30:23];
    fa     = s1_a[22:0];
    fb     = s1_b[22:0];
    sign_c = s1_a[31] ^ s1_b[31];
    a_nan  = (ea == 8'hFF) && (fa != 23'd0);
    b_nan  = (eb == 8'hFF) && (fb != 23'd0);
    a_inf  = (ea == 8'hFF) && (fa == 23'd0);
    b_inf  = (eb == 8'hFF) && (fb == 23'd0);
    // Exponent 0 covers both true zeros and flushed denormals.
    a_zero = (ea == 8'h00);
    b_zero = (eb == 8'h00);
    special_c     = 1'b1;
    special_val_c = QNAN;
    if (a_nan || b_nan) begin
      special_val_c = QNAN;
    end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
      special_val_c = QNAN;
    end else if (a_inf || b_inf) begin
      special_val_c = {sign_c, 8'hFF, 23'd0};
    end else if (a_zero || b_zero) begin
      special_val_c = {sign_c, 31'd0};
    end else begin
      special_c = 1'b0;
    end
  end

  // S6 round-to-nearest-even
  logic        round_up;
  logic [24:0] rounded;

  always_comb begin
    round_up = s5_guard & (s5_sticky | s5_sig[0]);
    rounded  = {1'b0, s5_sig} + {24'd0, round_up};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld <= '0;
    end else begin
      vld <= {vld[5:1], inp_data_ready};
    end
  end

  // Datapath stages carry no reset; validity is tracked by vld alone.
  always_ff @(posedge clock) begin
    if (inp_data_ready) begin
      s1_a <= inp_a[31:0];
      s1_b <= inp_b[31:0];
    end

    s2_sign        <= sign_c;
    s2_special     <= special_c;
    s2_special_val <= special_val_c;
    s2_exp         <= $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
    s2_ma          <= {1'b1, fa};
    s2_mb          <= {1'b1, fb};

    s3_sign        <= s2_sign;
    s3_special     <= s2_special;
    s3_special_val <= s2_special_val;
    s3_exp         <= s2_exp;
    s3_pp_lo       <= {12'd0, s2_ma} * {24'd0, s2_mb[11:0]};
    s3_pp_hi       <= {12'd0, s2_ma} * {24'd0, s2_mb[23:12]};

    s4_sign        <= s3_sign;
    s4_special     <= s3_special;
    s4_special_val <= s3_special_val;
    s4_exp         <= s3_exp;
    s4_prod        <= {12'd0, s3_pp_lo} + {s3_pp_hi, 12'd0};

    s5_sign        <= s4_sign;
    s5_special     <= s4_special;
    s5_special_val <= s4_special_val;
    s5_exp         <= s4_exp + $signed({9'd0, s4_prod[47]});
    if (s4_prod[47]) begin
      s5_sig    <= s4_prod[47:24];
      s5_guard  <= s4_prod[23];
      s5_sticky <= |s4_prod[22:0];
    end else begin
      s5_sig    <= s4_prod[46:23];
      s5_guard  <= s4_prod[22];
      s5_sticky <= |s4_prod[21:0];
    end

    s6_sign        <= s5_sign;
    s6_special     <= s5_special;
    s6_special_val <= s5_special_val;
    // A carry out of rounding leaves 1.000..0, so the shifted fraction is all zero.
    s6_exp         <= s5_exp + $signed({9'd0, rounded[24]});
    s6_frac        <= rounded[24] ? rounded[23:1] : rounded[22:0];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_product_ready <= 1'b0;
      out_product       <= '0;
    end else begin
      out_product_ready <= vld[6];
      if (vld[6]) begin
        if (s6_special) begin
          out_product <= s6_special_val;
        end else if (s6_exp >= 10'sd255) begin
          out_product <= {s6_sign, 8'hFF, 23'd0};
        end else if (s6_exp <= 10'sd0) begin
          out_product <= {s6_sign, 31'd0};
        end else begin
          out_product <= {s6_sign, s6_exp[7:0], s6_frac};
        end
      end
    end
  end

endmodule

// File: doc/fp32_multiplier_pipe.md
# fp32_multiplier_pipe

Fully pipelined IEEE-754 binary32 multiplier that sits on the responder side of the datapath's multiply handshake. Requesters present two operands with a one-cycle `inp_data_ready` strobe. Exactly 7 cycles later the block returns the product with a one-cycle `out_product_ready` pulse. It serves the exponentiation, polynomial and scaling sequencers, which wait out the fixed latency by counting cycles. It accepts a new operation every cycle.

## Interface
- `DATA_WIDTH`, default 32: operand/result width; 32 is the only supported value.
- `clock`  in  1: single clock, all logic on the rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `inp_a`  in  32: multiplicand, binary32.
- `inp_b`  in  32: multiplier, binary32.
- `inp_data_ready`  in  1: operand-valid strobe; operands are sampled on any edge where it is high.
- `out_product_ready`  out  1: one-cycle pulse per accepted operation; product valid on `out_product` that cycle.
- `out_product`  out  32: binary32 product; holds the last result between pulses.

## Operation
- Seven register stages, each with its own valid bit:
  - S1: capture and unpack operands.
  - S2: classify special cases, compute sign, form biased exponent sum.
  - S3–S4: 24x24 mantissa multiply, split across two stages as partial-product halves then sum.
  - S5: normalize (48-bit product, shift by 0 or 1, exponent adjust).
  - S6: round.
  - S7: pack into the output registers.
- Sign is `a[31] ^ b[31]`, including zero, infinity and NaN-free special results.
- Exponent arithmetic is carried 10 bits signed. The sum is `ea + eb - 127`, plus 1 if the product's MSB is set.
- Rounding: round-to-nearest-even on the 24-bit significand using guard and sticky bits. If rounding carries out, renormalize and increment the exponent.
- Special cases are evaluated in S2 and override the arithmetic path:
  - Either input NaN -> `0x7FC00000` (canonical quiet NaN, sign ignored).
  - Infinity times zero -> `0x7FC00000`.
  - Infinity times finite nonzero -> signed infinity.
  - Zero times finite -> signed zero.
- Denormals are flushed to zero:
  - A denormal input (exponent 0, fraction ≠ 0) is treated as signed zero.
  - A result exponent ≤ 0 after rounding gives signed zero.
- Overflow: a result exponent ≥ 255 after rounding gives signed infinity (`0x7F800000` / `0xFF800000`).
- No flow control: there is no backpressure and no stall. Every strobe produces exactly one result, in order.

## Timing
- Strobe high at rising edge N:
  - Operands are captured into S1 at edge N.
  - `out_product` and `out_product_ready` update at edge N+6.
  - Seen from the requester, the result is valid during the 7th cycle after the cycle in which the strobe was driven.
- Latency is fixed at 7 and is independent of operand values and special cases.
- Back-to-back strobes on consecutive edges produce consecutive ready pulses in the same order.
- `out_product_ready` is high for exactly one cycle per operation, and is never high without a corresponding strobe.
- `out_product` changes only on edges where `out_product_ready` is asserted; otherwise it holds.
- Reset values: `out_product_ready` = 0, `out_product` = `0x00000000`, all stage valid bits 0. Datapath registers other than the outputs need not be reset.
- Reset asserted mid-operation:
  - All in-flight operations are discarded, with no ready pulse for them afterwards.
  - The outputs go to their reset values immediately (asynchronously).
- First strobe after reset deassertion: the strobe may be high at the first rising edge after `reset_n` rises. It is accepted normally.
- Operand changes while the strobe is low have no effect on the outputs.

## Test plan
- Basic product: `0x40000000` × `0x40400000` (2.0 × 3.0) with strobe at edge 10 -> `out_product_ready` pulse and `0x40C00000` at edge 16. `out_product` holds that value at edges 17–20.
- Sign and rounding:
  - `0xC0000000` × `0x40400000` -> `0xC0C00000`.
  - `0x3FC00000` × `0x3FC00000` -> `0x40100000`.
  - `0x3F800001` × `0x3F800001` -> `0x3F800002`.
- Specials:
  - `0x7F800000` × `0x00000000` -> `0x7FC00000`.
  - `0xFF800000` × `0x40000000` -> `0xFF800000`.
  - `0x7FC00001` × `0x3F800000` -> `0x7FC00000`.
- Range limits:
  - `0x7F7FFFFF` × `0x40000000` -> `0x7F800000`.
  - `0x00800000` × `0x3F000000` -> `0x00000000`.
  - `0x00000001` × `0x40000000` -> `0x00000000`.
- Throughput: five strobes on consecutive edges with operand pairs (k+1.0) × 2.0 for k=0..4 -> five consecutive ready pulses carrying 2.0, 4.0, 6.0, 8.0, 10.0 (`0x40000000`, `0x40800000`, `0x40C00000`, `0x41000000`, `0x41200000`).
- Reset mid-flight: strobe three operations, pull `reset_n` low 3 cycles later between clock edges -> outputs go to 0 immediately. No ready pulse follows within 10 cycles of release. A fresh strobe after release returns the correct product 7 cycles later.
